// File: rtl/post_adder_acc.sv
// post_adder_acc: DSP48A1 post-adder / accumulator stage.
// Selects X/Z operands by OPMODE, adds or subtracts with carry-in into P.
// Ports:
//   CLK, RST (async, active-high)
//   CEP, CEOPMODE, CECARRYIN: per-register clock enables
//   OPMODE: [1:0] X sel, [3:2] Z sel, [5] carry bit, [7] subtract
//   M, DAB, C, PCIN: datapath operands; CARRYIN: external carry-in
//   P / PCOUT: result and cascade copy
//   CARRYOUT / CARRYOUTF: carry or borrow out and its fabric copy
module post_adder_acc #(
  parameter int WIDTH       = 48,
  parameter int MWIDTH      = 36,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int OPMODEREG   = 1,
  parameter int CARRYINREG  = 1,
  parameter     CARRYINSEL  = "OPMODE5"
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CEP,
  input  logic              CEOPMODE,
  input  logic              CECARRYIN,
  input  logic [7:0]        OPMODE,
  input  logic [MWIDTH-1:0] M,
  input  logic [WIDTH-1:0]  DAB,
  input  logic [WIDTH-1:0]  C,
  input  logic [WIDTH-1:0]  PCIN,
  input  logic              CARRYIN,
  output logic [WIDTH-1:0]  P,
  output logic [WIDTH-1:0]  PCOUT,
  output logic              CARRYOUT,
  output logic              CARRYOUTF
);

  localparam int CSRC =
    (CARRYINSEL == "OPMODE5") ? 1 :
    (CARRYINSEL == "CARRYIN") ? 2 : 0;

  logic [7:0]       opm_r;
  logic [7:0]       opm;
  logic             cin_src;
  logic             cin_r;
  logic             cin;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] p_fb;
  logic             co_r;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] z;
  logic [WIDTH:0]   xe;
  logic [WIDTH:0]   ze;
  logic [WIDTH:0]   ce;
  logic [WIDTH:0]   sum;
  logic             unused_opm;

  // Bits 4 and 6 belong to the pre-adder upstream.
  assign unused_opm = opm[4] ^ opm[6];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      opm_r <= '0;
    else if (CEOPMODE)
      opm_r <= OPMODE;
  end

  assign opm = (OPMODEREG != 0) ? opm_r : OPMODE;

  // Carry source sampled alongside OPMODE so both
  // land on the same edge.
  assign cin_src = (CSRC == 1) ? OPMODE[5] :
                   (CSRC == 2) ? CARRYIN   : 1'b0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cin_r <= 1'b0;
    else if (CECARRYIN)
      cin_r <= cin_src;
  end

  assign cin = (CARRYINREG != 0) ? cin_r : cin_src;

  // Without the P register, feedback reads 0 so no
  // combinational loop through the adder exists.
  assign p_fb = (PREG != 0) ? p_r : '0;

  always_comb begin
    x = '0;
    unique case (opm[1:0])
      2'd0: x = '0;
      2'd1: x = {{(WIDTH-MWIDTH){1'b0}}, M};
      2'd2: x = p_fb;
      2'd3: x = DAB;
    endcase
  end

  always_comb begin
    z = '0;
    unique case (opm[3:2])
      2'd0: z = '0;
      2'd1: z = PCIN;
      2'd2: z = p_fb;
      2'd3: z = C;
    endcase
  end

  assign xe = {1'b0, x};
  assign ze = {1'b0, z};
  assign ce = {{WIDTH{1'b0}}, cin};

  // Bit WIDTH is the carry when adding, the borrow
  // when subtracting.
  assign sum = opm[7] ? (ze - (xe + ce))
                      : (ze + xe + ce);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      p_r <= '0;
    else if (CEP)
      p_r <= sum[WIDTH-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      co_r <= 1'b0;
    else if (CEP)
      co_r <= sum[WIDTH];
  end

  // Combinational outputs are still forced low under reset.
  assign P = (PREG != 0) ? p_r :
             (RST ? '0 : sum[WIDTH-1:0]);

  assign CARRYOUT = (CARRYOUTREG != 0) ? co_r :
                    (RST ? 1'b0 : sum[WIDTH]);

  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_post_adder_acc.sv
// tb_post_adder_acc: directed bench for post_adder_acc.
// Registered instance plus a fully combinational cascade instance.
module tb_post_adder_acc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CEP, CEOPMODE, CECARRYIN;
  logic [7:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] DAB, C, PCIN;
  logic        CARRYIN;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  logic [7:0]  b_opmode;
  logic [35:0] b_m;
  logic [47:0] b_dab, b_c, b_pcin;
  logic        b_carryin;
  logic [47:0] b_p, b_pcout;
  logic        b_co, b_cof;

  int ntests = 0;
  int nfail  = 0;

  always #5 CLK = ~CLK;

  post_adder_acc u0 (
    .CLK(CLK), .RST(RST), .CEP(CEP),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C),
    .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  post_adder_acc #(
    .PREG(0), .CARRYOUTREG(0),
    .OPMODEREG(0), .CARRYINREG(0),
    .CARRYINSEL("CARRYIN")
  ) u1 (
    .CLK(CLK), .RST(RST), .CEP(CEP),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .OPMODE(b_opmode), .M(b_m), .DAB(b_dab), .C(b_c),
    .PCIN(b_pcin), .CARRYIN(b_carryin),
    .P(b_p), .PCOUT(b_pcout),
    .CARRYOUT(b_co), .CARRYOUTF(b_cof)
  );

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    CEP = 1'b0; CEOPMODE = 1'b0; CECARRYIN = 1'b0;
    OPMODE = 8'h00; M = '0; DAB = '0; C = '0;
    PCIN = '0; CARRYIN = 1'b0;
    b_opmode = 8'h00; b_m = '0; b_dab = '0;
    b_c = '0; b_pcin = '0; b_carryin = 1'b0;
    #12;
    chk("rst_p", P, 48'd0);
    chk("rst_pcout", PCOUT, 48'd0);
    chk("rst_co", {47'd0, CARRYOUT}, 48'd0);
    chk("rst_cof", {47'd0, CARRYOUTF}, 48'd0);

    // Multiply-add: X=M, Z=C
    step();
    RST = 1'b0;
    CEP = 1'b1; CEOPMODE = 1'b1; CECARRYIN = 1'b1;
    OPMODE = 8'h0D; M = 36'd1000; C = 48'd5;
    step();
    chk("madd_lat", P, 48'd0);
    step();
    chk("madd_p", P, 48'd1005);
    chk("madd_pcout", PCOUT, 48'd1005);
    chk("madd_co", {47'd0, CARRYOUT}, 48'd0);

    // Async reset mid-cycle
    C = 48'h123; M = '0;
    step();
    chk("pre_rst_p", P, 48'h123);
    #3 RST = 1'b1;
    #1;
    chk("arst_p", P, 48'd0);
    chk("arst_pcout", PCOUT, 48'd0);
    chk("arst_co", {47'd0, CARRYOUT}, 48'd0);
    for (int i = 0; i < 3; i++) begin
      CEP = ~CEP;
      step();
      chk("rst_hold_p", P, 48'd0);
    end
    CEP = 1'b1;

    // Preload all-ones, then accumulate with wrap
    OPMODE = 8'h0C; C = 48'hFFFF_FFFF_FFFF;
    RST = 1'b0;
    step();
    chk("restart_p", P, 48'd0);
    step();
    chk("preload_p", P, 48'hFFFF_FFFF_FFFF);
    OPMODE = 8'h09; M = 36'd1;
    step();
    chk("old_opm_p", P, 48'hFFFF_FFFF_FFFF);
    chk("old_opm_co", {47'd0, CARRYOUT}, 48'd0);
    step();
    chk("wrap_p", P, 48'd0);
    chk("wrap_co", {47'd0, CARRYOUT}, 48'd1);
    chk("wrap_cof", {47'd0, CARRYOUTF}, 48'd1);
    step();
    chk("acc1_p", P, 48'd1);
    chk("acc1_co", {47'd0, CARRYOUT}, 48'd0);

    // Subtract with borrow: 3 - 5
    OPMODE = 8'h8D; C = 48'd3; M = 36'd5;
    step();
    step();
    chk("sub_p", P, 48'hFFFF_FFFF_FFFE);
    chk("sub_co", {47'd0, CARRYOUT}, 48'd1);

    // Carry-in from OPMODE[5]
    OPMODE = 8'h2D; C = '0; M = '0;
    step();
    step();
    chk("cin_p", P, 48'd1);
    chk("cin_co", {47'd0, CARRYOUT}, 48'd0);

    // CEP low freezes P while C changes
    CEP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      C = 48'd7 + 48'(i);
      step();
      chk("hold_p", P, 48'd1);
    end

    // Combinational cascade instance
    b_opmode = 8'h07; b_pcin = 48'd10; b_dab = 48'd20;
    #1;
    chk("casc_p", b_p, 48'd30);
    chk("casc_pcout", b_pcout, 48'd30);
    b_opmode = 8'h0B;
    #1;
    chk("zp_zero", b_p, 48'd20);
    b_opmode = 8'h0A;
    #1;
    chk("xzp_zero", b_p, 48'd0);
    b_opmode = 8'h27;
    #1;
    chk("opm5_ignored", b_p, 48'd30);
    b_carryin = 1'b1;
    #1;
    chk("ext_cin", b_p, 48'd31);
    b_opmode = 8'h87;
    #1;
    chk("csub_p", b_p, 48'hFFFF_FFFF_FFF5);
    chk("csub_co", {47'd0, b_co}, 48'd1);
    chk("csub_cof", {47'd0, b_cof}, 48'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
